// File: rtl/servo_ramp.sv
// servo_ramp: bus-mapped motion sequencer that walks a servo position toward a
// programmed target, one step per programmed interval. Each new position is
// presented to the PWM peripheral with a one-cycle strobe.
//
// Register map (byte offsets from SERVO_RAMP_ADDRESS):
//   +0 TARGET (RW)   +1 STEP (RW, 0 behaves as 1)   +2 RATE (RW, step every RATE+1 ticks)
//   +3 CTRL (RW): bit0 enable, bit1 irq_en, bit4 busy (RO), bit5 done (W1C)
//   +4 POS (RO)
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   din, address    bus write data / address
//   w_en, r_en      single-cycle bus write / read strobes
//   dout            registered read data (0 when no mapped read)
//   pos_out         current position to the PWM peripheral
//   pos_valid       one-cycle write strobe for pos_out
//   busy            ramp in progress
//   irq             done & irq_en
//
// Build option: define SERVO_RAMP_IRQ_EN to implement CTRL.irq_en and the
// interrupt; otherwise irq_en reads 0 and irq is tied low.

module servo_ramp #(
  parameter logic [7:0] SERVO_RAMP_ADDRESS = 8'h00,
  parameter int         CLK_TICK_DIV       = 16000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic [7:0] address,
  input  logic       w_en,
  input  logic       r_en,
  output logic [7:0] dout,
  output logic [7:0] pos_out,
  output logic       pos_valid,
  output logic       busy,
  output logic       irq
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_MOVE = 2'd2;

  localparam logic [15:0] TICK_LAST = 16'(CLK_TICK_DIV - 1);

  localparam logic [7:0] A_TARGET = SERVO_RAMP_ADDRESS;
  localparam logic [7:0] A_STEP   = SERVO_RAMP_ADDRESS + 8'd1;
  localparam logic [7:0] A_RATE   = SERVO_RAMP_ADDRESS + 8'd2;
  localparam logic [7:0] A_CTRL   = SERVO_RAMP_ADDRESS + 8'd3;
  localparam logic [7:0] A_POS    = SERVO_RAMP_ADDRESS + 8'd4;

  // Saturating moves use a 9-bit intermediate so the position never wraps.
  function automatic logic [7:0] step_up(input logic [7:0] p, input logic [7:0] s,
                                         input logic [7:0] t);
    logic [8:0] sum;
    sum = {1'b0, p} + {1'b0, s};
    return (sum >= {1'b0, t}) ? t : sum[7:0];
  endfunction

  function automatic logic [7:0] step_down(input logic [7:0] p, input logic [7:0] s,
                                           input logic [7:0] t);
    logic [8:0] diff;
    diff = {1'b0, p} - {1'b0, s};
    return (diff[8] || (diff[7:0] <= t)) ? t : diff[7:0];
  endfunction

  logic [7:0]  target;
  logic [7:0]  step;
  logic [7:0]  rate;
  logic        enable;
  logic        irq_en_bit;
  logic        done;
  logic [7:0]  pos;
  logic [1:0]  state;
  logic [7:0]  rate_cnt;
  logic [15:0] tick_cnt;
  logic        tick;

  logic        wr_target, wr_step, wr_rate, wr_ctrl;
  logic [7:0]  eff_step;
  logic [7:0]  next_pos;
  logic        done_set;
  logic [7:0]  rd_data;

  assign wr_target = w_en && (address == A_TARGET);
  assign wr_step   = w_en && (address == A_STEP);
  assign wr_rate   = w_en && (address == A_RATE);
  assign wr_ctrl   = w_en && (address == A_CTRL);

  assign eff_step = (step == 8'd0) ? 8'd1 : step;
  assign tick     = (tick_cnt == TICK_LAST);
  assign busy     = (state != S_IDLE);
  assign pos_out  = pos;

  always_comb begin
    next_pos = pos;
    if (target > pos)      next_pos = step_up(pos, eff_step, target);
    else if (target < pos) next_pos = step_down(pos, eff_step, target);
  end

  // Arrival either by a final move, or by enabling (0 -> 1) while already on target.
  always_comb begin
    done_set = 1'b0;
    if (state == S_MOVE && enable && next_pos == target)
      done_set = 1'b1;
    if (state == S_IDLE && wr_ctrl && din[0] && !enable && pos == target)
      done_set = 1'b1;
  end

`ifdef SERVO_RAMP_IRQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          irq_en_bit <= 1'b0;
    else if (wr_ctrl) irq_en_bit <= din[1];
  end
  assign irq = done & irq_en_bit;
`else
  assign irq_en_bit = 1'b0;
  assign irq        = 1'b0;
`endif

  always_comb begin
    rd_data = 8'd0;
    if (r_en) begin
      case (address)
        A_TARGET: rd_data = target;
        A_STEP:   rd_data = step;
        A_RATE:   rd_data = rate;
        A_CTRL:   rd_data = {2'b00, done, busy, 2'b00, irq_en_bit, enable};
        A_POS:    rd_data = pos;
        default:  rd_data = 8'd0;
      endcase
    end
  end

  // Free-running timebase; bus activity never disturbs it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)  tick_cnt <= 16'd0;
    else      tick_cnt <= tick ? 16'd0 : tick_cnt + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dout <= 8'd0;
    else     dout <= rd_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target    <= 8'd0;
      step      <= 8'd1;
      rate      <= 8'd0;
      enable    <= 1'b0;
      done      <= 1'b0;
      pos       <= 8'd0;
      pos_valid <= 1'b0;
      state     <= S_IDLE;
      rate_cnt  <= 8'd0;
    end else begin
      pos_valid <= 1'b0;
      if (wr_target) target <= din;
      if (wr_step)   step   <= din;
      if (wr_rate)   rate   <= din;
      if (wr_ctrl)   enable <= din[0];

      // Set beats a simultaneous write-one-to-clear.
      if (done_set)                done <= 1'b1;
      else if (wr_ctrl && din[5])  done <= 1'b0;

      case (state)
        S_IDLE: begin
          if (enable && pos != target) begin
            state    <= S_WAIT;
            rate_cnt <= rate;
          end
        end
        S_WAIT: begin
          if (!enable) state <= S_IDLE;
          else if (tick) begin
            if (rate_cnt == 8'd0) state    <= S_MOVE;
            else                  rate_cnt <= rate_cnt - 8'd1;
          end
        end
        S_MOVE: begin
          if (!enable) state <= S_IDLE;
          else begin
            // Target may have been rewritten to pos: no change, no strobe.
            if (next_pos != pos) begin
              pos       <= next_pos;
              pos_valid <= 1'b1;
            end
            if (next_pos == target) state <= S_IDLE;
            else begin
              state    <= S_WAIT;
              rate_cnt <= rate;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
